game_tick_scheduler: RTL

//  Central timebase controller for the pong game. Replaces free-running per-object

---
 rtl/pong_pkg.sv | 35 +++
 rtl/game_tick_scheduler_tick_gen.sv | 42 ++++
 rtl/game_tick_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and default timing constants for the pong timebase.
// Periods are in system clock cycles (50 MHz reference).
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SERVE  = 2'b01,
    ST_RUN    = 2'b10,
    ST_PAUSED = 2'b11
  } game_state_e;

  localparam logic [31:0] DEF_BALL_PERIOD_INIT = 32'd833_333;
  localparam logic [31:0] DEF_BALL_PERIOD_MIN  = 32'd208_333;
  localparam logic [31:0] DEF_SPEEDUP_STEP     = 32'd41_667;
  localparam logic [31:0] DEF_PADDLE_PERIOD    = 32'd416_667;
  localparam logic [7:0]  DEF_SERVE_TICKS      = 8'd240;

  // Decrement that never underflows and never drops below the floor.
  function automatic logic [31:0] sat_dec(
    input logic [31:0] v,
    input logic [31:0] step,
    input logic [31:0] floor_v
  );
    logic [31:0] d;
    if (v < step) begin
      return floor_v;
    end
    d = v - step;
    if (d < floor_v) begin
      return floor_v;
    end
    return d;
  endfunction

endpackage

// File: rtl/game_tick_scheduler_tick_gen.sv
// Programmable single-cycle enable generator.
// Counter freezes while disabled; tick is registered.
module tick_gen (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] r_cnt;
  logic        r_tick;
  logic        w_wrap;

  // Wrap when count reached period-1, or the period shrank under it.
  assign w_wrap = ({1'b0, r_cnt} + 33'd1) >= {1'b0, period};

  // Count enabled cycles and pulse on wrap.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (en) begin
      if (w_wrap) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + 32'd1;
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/game_tick_scheduler.sv
// Pong game phase sequencer and tick scheduler.
// Gates ball/paddle ticks and speeds the ball up per hit.
module game_tick_scheduler
  import pong_pkg::*;
#(
  parameter logic [31:0] BALL_PERIOD_INIT = DEF_BALL_PERIOD_INIT,
  parameter logic [31:0] BALL_PERIOD_MIN  = DEF_BALL_PERIOD_MIN,
  parameter logic [31:0] SPEEDUP_STEP     = DEF_SPEEDUP_STEP,
  parameter logic [31:0] PADDLE_PERIOD    = DEF_PADDLE_PERIOD,
  parameter logic [7:0]  SERVE_TICKS      = DEF_SERVE_TICKS
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        hit,
  input  logic        point_scored,
  output logic        ball_tick,
  output logic        paddle_tick,
  output logic [1:0]  state,
  output logic [31:0] ball_period
);

  game_state_e r_state;
  game_state_e r_resume;
  logic [7:0]  r_serve_cnt;
  logic [31:0] r_ball_period;

  game_state_e w_state_nxt;
  logic        w_point;
  logic        w_save;
  logic        w_serve_clr;
  logic        w_serve_inc;
  logic        w_ball_clr;
  logic        w_hit_dec;
  logic        w_ball_en;
  logic        w_paddle_en;

  // Phase, resume phase, serve count and ball period registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_resume      <= ST_SERVE;
      r_serve_cnt   <= '0;
      r_ball_period <= BALL_PERIOD_INIT;
    end else begin
      r_state <= w_state_nxt;
      if (w_save) begin
        r_resume <= r_state;
      end
      if (w_serve_clr) begin
        r_serve_cnt <= '0;
      end else if (w_serve_inc) begin
        r_serve_cnt <= r_serve_cnt + 8'd1;
      end
      if (w_point) begin
        r_ball_period <= BALL_PERIOD_INIT;
      end else if (w_hit_dec) begin
        r_ball_period <= sat_dec(r_ball_period, SPEEDUP_STEP,
                                 BALL_PERIOD_MIN);
      end
    end
  end

  // Next phase and side effects, point > pause > per-state rules.
  always_comb begin
    w_state_nxt = r_state;
    w_point     = 1'b0;
    w_save      = 1'b0;
    w_serve_clr = 1'b0;
    w_serve_inc = 1'b0;
    w_ball_clr  = 1'b0;
    w_hit_dec   = 1'b0;
    if (point_scored && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_SERVE;
      w_point     = 1'b1;
      w_ball_clr  = 1'b1;
      w_serve_clr = 1'b1;
    end else if (pause && ((r_state == ST_SERVE) ||
                           (r_state == ST_RUN))) begin
      w_state_nxt = ST_PAUSED;
      w_save      = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_SERVE;
            w_serve_clr = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            w_state_nxt = r_resume;
          end
        end
        ST_SERVE: begin
          if (paddle_tick) begin
            w_serve_inc = 1'b1;
            if (r_serve_cnt == (SERVE_TICKS - 8'd1)) begin
              w_state_nxt = ST_RUN;
              w_ball_clr  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          w_hit_dec = hit;
        end
      endcase
    end
  end

  // Counter enables and visible outputs from the current phase.
  always_comb begin
    w_ball_en   = (r_state == ST_RUN);
    w_paddle_en = (r_state == ST_SERVE) || (r_state == ST_RUN);
    state       = r_state;
    ball_period = r_ball_period;
  end

  tick_gen u_ball (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (w_ball_en),
    .clr    (w_ball_clr),
    .period (r_ball_period),
    .tick   (ball_tick)
  );

  tick_gen u_paddle (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (w_paddle_en),
    .clr    (1'b0),
    .period (PADDLE_PERIOD),
    .tick   (paddle_tick)
  );

endmodule
